wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the pipeline writeback stage (MEM/WB register outputs) and the multi-cycle multiply/divide unit (MDU). Pipeline writeback always has priority. MDU results wait in a one-entry holding register. If a pending MDU result is starved for too long, the block raises a registered stall request so the pipeline injects a bubble into MEM/WB and frees the port.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_hold_slot.sv | 47 ++++
 rtl/wb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the writeback port arbiter and its hold slot.
// Control-byte bit positions, FSM states and the x0 register index.
package riscv_pkg;

    localparam int WB_CTRL_REGWRITE = 0;
    localparam int WB_CTRL_MEMTOREG = 1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for MDU results waiting on the RF write port.
// Owns the accept, drain and WAW-kill decisions for the entry.
module wb_hold_slot
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    input  logic            pipe_req,
    input  logic [4:0]      wb_reg_addr,
    output logic            hold_v,
    output logic [4:0]      hold_rd,
    output logic [XLEN-1:0] hold_data,
    output logic            drain,
    output logic            kill,
    output logic            capture,
    output logic            ready
);

    logic accept;

    assign drain   = hold_v & ~pipe_req;
    assign kill    = hold_v & pipe_req & (wb_reg_addr == hold_rd);
    assign ready   = rst_n & (~hold_v | drain);
    assign accept  = mdu_valid & ready;
    // Results for x0 are taken off the MDU but never occupy the slot.
    assign capture = accept & (mdu_rd != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v    <= 1'b0;
            hold_rd   <= REG_ZERO;
            hold_data <= '0;
        end else if (accept) begin
            hold_v    <= capture;
            hold_rd   <= mdu_rd;
            hold_data <= mdu_data;
        end else if (drain | kill) begin
            hold_v <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port between MEM/WB and the MDU hold slot.
// Pipeline always wins; a starved MDU entry raises a registered stall request.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      wb_reg_addr,
    input  logic [7:0]      wb_control,
    input  logic [XLEN-1:0] wb_memdata,
    input  logic [XLEN-1:0] wb_regdata,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            wb_src,
    output logic            pipe_stall_req
);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic            pipe_req;
    logic            hold_v;
    logic [4:0]      hold_rd;
    logic [XLEN-1:0] hold_data;
    logic            drain;
    logic            kill;
    logic            capture;
    logic            unused_ctrl;

    assign unused_ctrl = &{1'b0, wb_control[7:2]};

    assign pipe_req = rst_n
                    & wb_control[WB_CTRL_REGWRITE]
                    & (wb_reg_addr != REG_ZERO);

    wb_hold_slot #(
        .XLEN (XLEN)
    ) u_slot (
        .clk         (clk),
        .rst_n       (rst_n),
        .mdu_valid   (mdu_valid),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .pipe_req    (pipe_req),
        .wb_reg_addr (wb_reg_addr),
        .hold_v      (hold_v),
        .hold_rd     (hold_rd),
        .hold_data   (hold_data),
        .drain       (drain),
        .kill        (kill),
        .capture     (capture),
        .ready       (mdu_ready)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = REG_ZERO;
        rf_wdata = '0;
        wb_src   = 1'b0;
        if (pipe_req) begin
            rf_we    = 1'b1;
            rf_waddr = wb_reg_addr;
            rf_wdata = wb_control[WB_CTRL_MEMTOREG]
                     ? wb_memdata : wb_regdata;
        end else if (hold_v) begin
            rf_we    = 1'b1;
            rf_waddr = hold_rd;
            rf_wdata = hold_data;
            wb_src   = 1'b1;
        end
    end

    // cnt counts consecutive cycles the held entry lost to the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            pipe_stall_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        state <= PEND;
                        cnt   <= '0;
                    end
                end
                PEND: begin
                    if (drain | kill) begin
                        state <= capture ? PEND : IDLE;
                        cnt   <= '0;
                    end else if (pipe_req) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(STARVE_MAX - 2)) begin
                            state          <= DRAIN;
                            pipe_stall_req <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain | kill) begin
                        state          <= capture ? PEND : IDLE;
                        cnt            <= '0;
                        pipe_stall_req <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    cnt            <= '0;
                    pipe_stall_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed cases plus random traffic
// checked against an entry/age reference model.
module tb_wb_port_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [4:0]      wb_reg_addr = '0;
    logic [7:0]      wb_control = '0;
    logic [XLEN-1:0] wb_memdata = '0;
    logic [XLEN-1:0] wb_regdata = '0;
    logic            mdu_valid = 1'b0;
    logic            mdu_ready;
    logic [4:0]      mdu_rd = '0;
    logic [XLEN-1:0] mdu_data = '0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            wb_src;
    logic            pipe_stall_req;

    wb_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_reg_addr    (wb_reg_addr),
        .wb_control     (wb_control),
        .wb_memdata     (wb_memdata),
        .wb_regdata     (wb_regdata),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_rd         (mdu_rd),
        .mdu_data       (mdu_data),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .wb_src         (wb_src),
        .pipe_stall_req (pipe_stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      a;
        logic [XLEN-1:0] d;
        logic            s;
    } wr_t;

    typedef struct {
        logic we;
        logic rdy;
        logic stall;
    } st_t;

    wr_t wr_q[$];
    st_t st_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: an optional pending entry and its age in lost cycles.
    bit              m_hv;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    int              m_lost;
    bit              m_stall;

    bit              n_hv;
    logic [4:0]      n_rd;
    logic [XLEN-1:0] n_data;
    int              n_lost;
    bit              n_stall;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hv = 0; m_rd = '0; m_data = '0; m_lost = 0; m_stall = 0;
    endtask

    task automatic model_eval();
        bit  pr;
        bit  drain;
        bit  kill;
        bit  rdy;
        bit  acc;
        wr_t w;
        st_t s;
        pr = wb_control[0] && (wb_reg_addr != 0);
        s.we = 1'b0;
        if (pr) begin
            w.a = wb_reg_addr;
            w.d = wb_control[1] ? wb_memdata : wb_regdata;
            w.s = 1'b0;
            wr_q.push_back(w);
            s.we = 1'b1;
        end else if (m_hv) begin
            w.a = m_rd;
            w.d = m_data;
            w.s = 1'b1;
            wr_q.push_back(w);
            s.we = 1'b1;
        end
        drain = m_hv && !pr;
        kill  = m_hv && pr && (wb_reg_addr == m_rd);
        rdy   = !m_hv || drain;
        acc   = mdu_valid && rdy;
        s.rdy = rdy;
        s.stall = m_stall;
        st_q.push_back(s);
        n_hv = m_hv; n_rd = m_rd; n_data = m_data; n_lost = m_lost;
        if (acc && mdu_rd != 0) begin
            n_hv = 1; n_rd = mdu_rd; n_data = mdu_data; n_lost = 0;
        end else if (drain || kill) begin
            n_hv = 0; n_lost = 0;
        end else if (m_hv) begin
            n_lost = m_lost + 1;
        end
        n_stall = n_hv && (n_lost >= STARVE_MAX - 1);
    endtask

    task automatic step(input logic [7:0] ctl, input logic [4:0] a,
                        input logic [XLEN-1:0] md,
                        input logic [XLEN-1:0] rdat,
                        input logic mv, input logic [4:0] mrd,
                        input logic [XLEN-1:0] mdat);
        wb_control = ctl; wb_reg_addr = a;
        wb_memdata = md;  wb_regdata = rdat;
        mdu_valid = mv;   mdu_rd = mrd; mdu_data = mdat;
        #1;
        model_eval();
        @(posedge clk);
        m_hv = n_hv; m_rd = n_rd; m_data = n_data;
        m_lost = n_lost; m_stall = n_stall;
        #1;
    endtask

    task automatic idle(input logic mv, input logic [4:0] mrd,
                        input logic [XLEN-1:0] mdat);
        step(8'h00, 5'd0, '0, '0, mv, mrd, mdat);
    endtask

    task automatic pipe(input logic [4:0] a, input logic [XLEN-1:0] v);
        step(8'h01, a, '0, v, 1'b0, 5'd0, '0);
    endtask

    // Monitor: pops one status record per checked cycle, one write per rf_we.
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(negedge clk);
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("rf_we", 64'(rf_we), 64'(s.we));
                chk("mdu_ready", 64'(mdu_ready), 64'(s.rdy));
                chk("stall_req", 64'(pipe_stall_req), 64'(s.stall));
                if (rf_we === 1'b1) begin
                    if (wr_q.size() == 0) begin
                        chk("extra_write", 64'd1, 64'd0);
                    end else begin
                        w = wr_q.pop_front();
                        chk("rf_waddr", 64'(rf_waddr), 64'(w.a));
                        chk("rf_wdata", 64'(rf_wdata), 64'(w.d));
                        chk("wb_src", 64'(wb_src), 64'(w.s));
                    end
                end
            end
        end
    end

    initial begin
        int burst;
        logic [7:0] ctl;
        model_reset();
        wb_control = 8'h03; wb_reg_addr = 5'd6;
        mdu_valid = 1'b1; mdu_rd = 5'd2;
        #12;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_wb_src", 64'(wb_src), 64'd0);
        chk("rst_ready", 64'(mdu_ready), 64'd0);
        chk("rst_stall", 64'(pipe_stall_req), 64'd0);
        wb_control = '0; mdu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        step(8'h01, 5'd5, '0, 32'hA5A5_0001, 1'b0, 5'd0, '0);
        step(8'h03, 5'd5, 32'h1234, 32'hFFFF_0000, 1'b0, 5'd0, '0);
        step(8'h01, 5'd0, '0, 32'h9, 1'b0, 5'd0, '0);

        idle(1'b1, 5'd7, 32'hDEAD_BEEF);
        idle(1'b0, 5'd0, '0);
        idle(1'b0, 5'd0, '0);

        idle(1'b1, 5'd9, 32'h0000_0099);
        pipe(5'd1, 32'h11);
        pipe(5'd2, 32'h22);
        pipe(5'd3, 32'h33);
        pipe(5'd4, 32'h44);
        idle(1'b0, 5'd0, '0);
        idle(1'b0, 5'd0, '0);

        idle(1'b1, 5'd12, 32'h77);
        pipe(5'd12, 32'h55);
        idle(1'b0, 5'd0, '0);
        idle(1'b0, 5'd0, '0);

        idle(1'b1, 5'd4, 32'h44);
        idle(1'b1, 5'd3, 32'h33);
        idle(1'b0, 5'd0, '0);
        idle(1'b1, 5'd0, 32'hBAD);
        idle(1'b0, 5'd0, '0);

        burst = 0;
        for (int i = 0; i < 600; i++) begin
            ctl = 8'($urandom);
            if (burst > 0) begin
                burst--;
                ctl[0] = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                burst = $urandom_range(3, 7);
            end
            step(ctl, 5'($urandom_range(0, 7)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom);
        end

        idle(1'b1, 5'd10, 32'h1010);
        pipe(5'd1, 32'h1);
        pipe(5'd2, 32'h2);
        pipe(5'd3, 32'h3);
        pipe(5'd4, 32'h4);
        wb_control = 8'h01; wb_reg_addr = 5'd5;
        mdu_valid = 1'b1; mdu_rd = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 64'(pipe_stall_req), 64'd0);
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_ready", 64'(mdu_ready), 64'd0);
        chk("mid_rst_waddr", 64'(rf_waddr), 64'd0);
        model_reset();
        wb_control = '0; mdu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b0, 5'd0, '0);
        idle(1'b0, 5'd0, '0);
        idle(1'b1, 5'd8, 32'h88);
        idle(1'b0, 5'd0, '0);
        idle(1'b0, 5'd0, '0);

        @(negedge clk);
        @(negedge clk);
        chk("status_q_empty", 64'(st_q.size()), 64'd0);
        chk("write_q_empty", 64'(wr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
